// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM port controller:
// size/state/owner codes and the common enable and zero constants.
package mem_ctrl_pkg;

    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_t;

    typedef enum logic {
        OwnerIF  = 1'b0,
        OwnerMEM = 1'b1
    } owner_t;

    // Size code 3 is not a legal encoding; it is served as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side and RAM-side signals of the memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_ready_o;
    logic [31:0]       if_data_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_ready_o;
    logic [31:0]       mem_rdata_o;

    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_ready_o, if_data_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_ready_o, mem_rdata_o,
        input  ram_din_i,
        output ram_dout_o, ram_a_o, ram_wr_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_ready_o, if_data_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_ready_o, mem_rdata_o,
        output ram_din_i,
        input  ram_dout_o, ram_a_o, ram_wr_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store,
// serialising 1/2/4-byte accesses into byte cycles with a one-cycle ready pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          MEM_FIRST = 1'b1
) (
    input logic       clk_in,
    input logic       rst_in,
    mem_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, mem_rdata_q;

    logic              if_ok, grant_if, grant_mem, rd_last;
    logic [2:0]        a_off;
    logic [1:0]        cap_idx;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr, if_ready, mem_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rbuf_d    = rbuf_q;
        if_ok     = 1'b0;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        rd_last   = 1'b0;
        a_off     = '0;
        cap_idx   = '0;
        ram_a     = '0;
        ram_dout  = '0;
        ram_wr    = Disable;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if_ok = bus.if_req_i && !bus.if_flush_i;
                if (bus.mem_req_i && (MEM_FIRST || !if_ok)) begin
                    grant_mem = 1'b1;
                    state_d   = bus.mem_we_i ? StWr : StRd;
                end else if (if_ok) begin
                    grant_if = 1'b1;
                    state_d  = StRd;
                end
            end
            StRd: begin
                // Count runs one past the last address: byte cnt-1 arrives
                // while the address bus holds the following (or final) address.
                a_off   = (cnt_q == len_q) ? cnt_q - 3'd1 : cnt_q;
                ram_a   = base_q + ADDR_W'(a_off);
                cap_idx = 2'(cnt_q - 3'd1);
                if (cnt_q != 3'd0) begin
                    rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
                end
                if (owner_q == OwnerIF && bus.if_flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == len_q) begin
                    rd_last = 1'b1;
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWr: begin
                ram_wr   = Enable;
                ram_a    = base_q + ADDR_W'(cnt_q);
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == len_q - 3'd1) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                if_ready  = (owner_q == OwnerIF);
                mem_ready = (owner_q == OwnerMEM);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_q     <= OwnerIF;
            base_q      <= '0;
            len_q       <= '0;
            wdata_q     <= ZeroWord;
            rbuf_q      <= ZeroWord;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_mem) begin
                owner_q <= OwnerMEM;
                base_q  <= bus.mem_addr_i;
                len_q   <= size_bytes(bus.mem_size_i);
                wdata_q <= bus.mem_wdata_i;
                rbuf_q  <= ZeroWord;
            end else if (grant_if) begin
                owner_q <= OwnerIF;
                base_q  <= bus.if_addr_i;
                len_q   <= 3'd4;
                rbuf_q  <= ZeroWord;
            end else begin
                rbuf_q <= rbuf_d;
            end
            if (rd_last) begin
                if (owner_q == OwnerIF) if_data_q   <= rbuf_d;
                else                    mem_rdata_q <= rbuf_d;
            end
        end
    end

    assign bus.ram_a_o     = ram_a;
    assign bus.ram_dout_o  = ram_dout;
    assign bus.ram_wr_o    = ram_wr;
    assign bus.if_ready_o  = if_ready;
    assign bus.mem_ready_o = mem_ready;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, hand-written corner sequences,
// and random single-requester traffic against a byte-array memory model.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .MEM_FIRST(1'b1)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // RAM: byte addressed in cycle t appears on ram_din_i in cycle t+1
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        logic [7:0] rd;
        rd = ram.exists(bus.ram_a_o) ? ram[bus.ram_a_o] : 8'h00;
        if (pl_en) ram[pl_addr] = pl_data;
        else if (bus.ram_wr_o === 1'b1) ram[bus.ram_a_o] = bus.ram_dout_o;
        bus.ram_din_i <= rd;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en      = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic int nbytes(input bit is_if, input logic [1:0] sz);
        if (is_if) return 4;
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai;
            ai = a + 32'(i);
            if (ref_mem.exists(ai)) v[8*i +: 8] = ref_mem[ai];
        end
        return v;
    endfunction

    function automatic void model_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    // One transaction from a single requester; reports latency (ticks from the
    // request cycle to ready, -1 on timeout), returned data and bus-cycle sanity.
    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] data, output int lat, output bit bus_ok);
        int   n;
        logic rdy;
        n      = nbytes(is_if, size);
        data   = '0;
        lat    = -1;
        bus_ok = 1'b1;
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = we;
            bus.mem_size_i  = size;
            bus.mem_addr_i  = addr;
            bus.mem_wdata_i = wdata;
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c <= n) begin
                if (bus.ram_a_o !== addr + 32'(c - 1)) bus_ok = 1'b0;
                if (bus.ram_wr_o !== we) bus_ok = 1'b0;
                if (we && bus.ram_dout_o !== wdata[8*(c-1) +: 8]) bus_ok = 1'b0;
            end else if (c == n + 1) begin
                if (bus.ram_wr_o !== 1'b0) bus_ok = 1'b0;
                if (!we && bus.ram_a_o !== addr + 32'(n - 1)) bus_ok = 1'b0;
            end
            if ((is_if ? bus.mem_ready_o : bus.if_ready_o) !== 1'b0) bus_ok = 1'b0;
            rdy = is_if ? bus.if_ready_o : bus.mem_ready_o;
            if (rdy === 1'b1) begin
                lat  = c;
                data = is_if ? bus.if_data_o : bus.mem_rdata_o;
                break;
            end
        end
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        tick();
        if (bus.if_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0 || bus.ram_wr_o !== 1'b0)
            bus_ok = 1'b0;
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] got, last_mem, if_hold;
        int          lat, mem_lat, if_lat;
        bit          ok, seen;

        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_0513, 6};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'hDEADBEEF, 32'h0,         5};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hDEADBEEF, 6};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0020, 32'h0,         32'hDEADBEEF, 6};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0030, 32'h0,         32'h0000_0080, 3};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_1234, 4};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0040, 32'hCAFEF00D, 32'h0,         3};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'h0000_F00D, 6};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0021, 32'h1234_56AB, 32'h0,         2};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hDEADABEF, 6};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0000_001F, 32'h0,         32'hADABEF00, 6};

        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.if_flush_i  = 1'b0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_size_i  = '0;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
        rst = 1'b1;
        repeat (3) tick();

        chk("reset_ram_a",     bus.ram_a_o, 32'h0);
        chk("reset_ram_wr",    32'(bus.ram_wr_o), 32'h0);
        chk("reset_ram_dout",  32'(bus.ram_dout_o), 32'h0);
        chk("reset_if_ready",  32'(bus.if_ready_o), 32'h0);
        chk("reset_mem_ready", 32'(bus.mem_ready_o), 32'h0);
        chk("reset_if_data",   bus.if_data_o, 32'h0);
        chk("reset_mem_rdata", bus.mem_rdata_o, 32'h0);
        rst = 1'b0;

        preload(32'h0000_0100, 8'h13);
        preload(32'h0000_0101, 8'h05);
        preload(32'h0000_0102, 8'h00);
        preload(32'h0000_0103, 8'h00);
        preload(32'h0000_0030, 8'h80);
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0000_0000, 8'h12);
        preload(32'h0000_0200, 8'h93);
        preload(32'h0000_0201, 8'h00);
        preload(32'h0000_0202, 8'h10);
        preload(32'h0000_0203, 8'h00);

        last_mem = 32'h0;
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    got, lat, ok);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_bus", i), 32'(ok), 32'd1);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_rdata_hold", i), bus.mem_rdata_o, last_mem);
                model_write(vecs[i].addr, nbytes(1'b0, vecs[i].size), vecs[i].wdata);
            end else begin
                chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
                if (!vecs[i].is_if) last_mem = vecs[i].exp_data;
            end
        end

        // Simultaneous requests: MEM first, IF served in the IDLE after DONE
        mem_lat = -1;
        if_lat  = -1;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_size_i  = 2'd0;
        bus.mem_addr_i  = 32'h30;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h100;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.mem_ready_o === 1'b1) begin
                mem_lat = c;
                chk("arb_mem_data", bus.mem_rdata_o, 32'h0000_0080);
                bus.mem_req_i = 1'b0;
            end
            if (bus.if_ready_o === 1'b1) begin
                if_lat = c;
                chk("arb_if_data", bus.if_data_o, 32'h0000_0513);
                bus.if_req_i = 1'b0;
                break;
            end
        end
        bus.mem_req_i = 1'b0;
        bus.if_req_i  = 1'b0;
        chk("arb_mem_latency", 32'(mem_lat), 32'd3);
        chk("arb_if_latency",  32'(if_lat), 32'd10);
        tick();

        // Flush while IF owns the port in RD
        if_hold         = 32'h0000_0513;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h100;
        tick();
        tick();
        bus.if_flush_i  = 1'b1;
        bus.if_req_i    = 1'b0;
        tick();
        bus.if_flush_i  = 1'b0;
        chk("flush_idle_addr", bus.ram_a_o, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.if_ready_o !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("flush_no_ready", 32'(seen), 32'd0);
        chk("flush_data_hold", bus.if_data_o, if_hold);
        run_txn(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, got, lat, ok);
        chk("after_flush_latency", 32'(lat), 32'd6);
        chk("after_flush_data", got, 32'h0010_0093);
        chk("after_flush_bus", 32'(ok), 32'd1);

        // Flush in the IDLE cycle blocks that cycle's IF grant
        if_lat         = -1;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h100;
        bus.if_flush_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.if_flush_i = 1'b0;
            if (bus.if_ready_o === 1'b1) begin
                if_lat = c;
                chk("idle_flush_data", bus.if_data_o, 32'h0000_0513);
                break;
            end
        end
        bus.if_req_i   = 1'b0;
        bus.if_flush_i = 1'b0;
        chk("idle_flush_latency", 32'(if_lat), 32'd7);
        tick();

        // Reset in the middle of a word store
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_size_i  = 2'd2;
        bus.mem_addr_i  = 32'h50;
        bus.mem_wdata_i = 32'h1122_3344;
        tick();
        tick();
        rst           = 1'b1;
        bus.mem_req_i = 1'b0;
        tick();
        chk("rst_mid_ram_wr",   32'(bus.ram_wr_o), 32'h0);
        chk("rst_mid_ram_a",    bus.ram_a_o, 32'h0);
        chk("rst_mid_ram_dout", 32'(bus.ram_dout_o), 32'h0);
        chk("rst_mid_if_data",  bus.if_data_o, 32'h0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.mem_ready_o !== 1'b0 || bus.ram_wr_o !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("rst_mid_no_ready", 32'(seen), 32'd0);
        run_txn(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, got, lat, ok);
        chk("after_rst_latency", 32'(lat), 32'd6);
        chk("after_rst_data", got, 32'hDEADABEF);

        // Random single-requester traffic against the byte-array model
        for (int t = 0; t < 40; t++) begin
            bit          r_if, r_we;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            int          n;
            r_if    = ($urandom_range(0, 3) == 0);
            r_we    = r_if ? 1'b0 : 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                  : 32'h60 + 32'($urandom_range(0, 63));
            r_wdata = $urandom;
            n       = nbytes(r_if, r_size);
            run_txn(r_if, r_we, r_size, r_addr, r_wdata, got, lat, ok);
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(r_we ? n + 1 : n + 2));
            chk($sformatf("rnd%0d_bus", t), 32'(ok), 32'd1);
            if (r_we) model_write(r_addr, n, r_wdata);
            else      chk($sformatf("rnd%0d_data", t), got, model_read(r_addr, n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide external RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into byte cycles and assembles or splits the 32-bit words.
- Returns a one-cycle ready pulse to the winning requester.
- Sits between the pipeline (IF, MEM stages and stall control) and the RAM bus; the MEM stage and stall control use mem_ready_o to release load-use stalls.

Parameters:
- ADDR_W, 32, width of all addresses.
- MEM_FIRST, 1, 1 = MEM wins simultaneous requests, 0 = IF wins.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- if_req_i  input  1  IF requests a 4-byte instruction read.
- if_addr_i  input  ADDR_W  fetch address.
- if_flush_i  input  1  abort any IF transaction (branch taken).
- if_ready_o  output  1  one-cycle pulse; if_data_o valid.
- if_data_o  output  32  fetched instruction, little-endian.
- mem_req_i  input  1  MEM requests an access.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_size_i  input  2  byte count: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes.
- mem_addr_i  input  ADDR_W  access base address.
- mem_wdata_i  input  32  store data; low bytes used first.
- mem_ready_o  output  1  one-cycle pulse; access complete.
- mem_rdata_o  output  32  load data, zero-extended; sign extension belongs to the MEM stage.
- ram_din_i  input  8  RAM read byte.
- ram_dout_o  output  8  RAM write byte.
- ram_a_o  output  ADDR_W  RAM byte address.
- ram_wr_o  output  1  1 = write cycle.

Behaviour:
- Reset (synchronous, rst_in high at a clock edge):
  - State goes to IDLE, byte counter to 0, owner cleared.
  - All outputs go to 0.
  - A transaction in progress is dropped with no ready pulse; ram_wr_o is low from the next cycle.
- RAM timing: address presented in cycle t; ram_din_i holds that byte in cycle t+1.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Sample requests at the cycle's edge; on a grant, latch address, size, wdata and owner.
  - Next state is RD for IF reads and MEM loads, WR for MEM stores.
  - Simultaneous requests: MEM wins if MEM_FIRST=1, otherwise IF wins. The loser keeps its request and is served later.
  - A grant is never preempted.
- RD, N bytes, request sampled at cycle T:
  - Cycles T+1..T+N: ram_a_o = base+k for k = 0..N-1, with ram_wr_o = 0.
  - Cycle T+N+1: one extra capture cycle with no new address; ram_a_o holds the last address.
  - Byte k is captured at cycle T+k+2 into bits [8k+7:8k]; unused upper bytes are 0.
  - Next state DONE at T+N+2, so a word read returns ready 6 cycles after its request is sampled.
- WR, N bytes:
  - Cycles T+1..T+N: ram_wr_o = 1, ram_a_o = base+k, ram_dout_o = wdata[8k+7:8k].
  - DONE at T+N+1.
- DONE:
  - Exactly one cycle: the owner's ready_o = 1, and its data output is valid for reads.
  - Requests are ignored in this cycle so the requester can drop its request; next state is IDLE.
- Outputs outside transfers:
  - ram_wr_o = 0 outside WR; ram_a_o and ram_dout_o = 0 in IDLE.
  - if_data_o and mem_rdata_o hold their last value until the next DONE of that owner.
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFFFFFF, byte 1 is at 0x00000000. Unaligned addresses are legal.
- if_flush_i:
  - If IF owns the port in RD, the next state is IDLE, the byte counter clears, and no if_ready_o is issued.
  - A flush in the IDLE cycle blocks the IF grant that cycle.
  - A flush during DONE does not retract the pulse; IF discards it.
  - A flush never affects a MEM transaction.
- A request changing while owned is ignored, because all fields are latched at grant.

Decomposition:
- Shared defines file gains:
  - size codes SizeByte, SizeHalf and SizeWord;
  - state codes for IDLE, RD, WR and DONE;
  - owner codes OwnerIF and OwnerMEM;
  - the existing Enable/Disable and ZeroWord constants, reused.
- Single module; no sub-module. The byte assembly and split logic is a few indexed assignments.

Test Plan:
- IF only, addr 0x100, RAM bytes 13 05 00 00 -> ram_a_o 0x100..0x103 in T+1..T+4; if_ready_o pulses at T+6 with if_data_o = 0x00000513.
- Store sw 0xDEADBEEF at 0x20 -> ram_wr_o high for T+1..T+4, bytes EF BE AD DE at 0x20..0x23; mem_ready_o at T+5.
- Both requests in the same IDLE cycle with MEM_FIRST=1, MEM load lbu 0x30 (byte 0x80) -> mem_rdata_o = 0x00000080 at T+3. IF is then granted in the first IDLE cycle after DONE, with no starvation.
- IF word read, if_flush_i high at T+2 -> IDLE at T+3 with no if_ready_o. A new IF request at 0x200 completes normally.
- lh at 0xFFFFFFFF -> ram_a_o = 0xFFFFFFFF then 0x00000000; mem_rdata_o = {16'h0, byte1, byte0}.
- rst_in high at T+2 of a sw -> from T+3 all outputs are 0 and ram_wr_o is low; no ready pulse; a subsequent request is served correctly.
